td4_register_stage: RTL and testbench

//   Architectural state of the TD4 4-bit CPU, directly downstream of the adder chain.

---
 rtl/td4_register_stage.sv | 77 +++++++
 tb/tb_td4_register_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/td4_register_stage.sv
// TD4 architectural state: A, B, OUT, program counter and carry flag, written back from the adder.
// Optional macro TD4_STEP_EN adds a step port that gates every update.
module td4_register_stage #(
    parameter int WIDTH    = 4,
    parameter int PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [WIDTH-1:0]    sum,
    input  logic                carry_out,
    input  logic [3:0]          load_n,
`ifdef TD4_STEP_EN
    input  logic                step,
`endif
    output logic [WIDTH-1:0]    reg_a,
    output logic [WIDTH-1:0]    reg_b,
    output logic [WIDTH-1:0]    reg_out,
    output logic [PC_WIDTH-1:0] pc,
    output logic                c_flag
);

    logic [WIDTH-1:0]    reg_a_q,   reg_a_d;
    logic [WIDTH-1:0]    reg_b_q,   reg_b_d;
    logic [WIDTH-1:0]    reg_out_q, reg_out_d;
    logic [PC_WIDTH-1:0] pc_q,      pc_d;
    logic                c_flag_q,  c_flag_d;
    logic                advance;

    // Jump targets come from the data-width adder; resize to the ROM address width.
    function automatic logic [PC_WIDTH-1:0] fit_pc(input logic [WIDTH-1:0] v);
        return PC_WIDTH'(v);
    endfunction

`ifdef TD4_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        reg_a_d   = reg_a_q;
        reg_b_d   = reg_b_q;
        reg_out_d = reg_out_q;
        pc_d      = pc_q;
        c_flag_d  = c_flag_q;
        if (advance) begin
            if (!load_n[0]) reg_a_d   = sum;
            if (!load_n[1]) reg_b_d   = sum;
            if (!load_n[2]) reg_out_d = sum;
            pc_d     = load_n[3] ? (pc_q + PC_WIDTH'(1)) : fit_pc(sum);
            c_flag_d = carry_out;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            reg_a_q   <= '0;
            reg_b_q   <= '0;
            reg_out_q <= '0;
            pc_q      <= '0;
            c_flag_q  <= 1'b0;
        end else begin
            reg_a_q   <= reg_a_d;
            reg_b_q   <= reg_b_d;
            reg_out_q <= reg_out_d;
            pc_q      <= pc_d;
            c_flag_q  <= c_flag_d;
        end
    end

    assign reg_a   = reg_a_q;
    assign reg_b   = reg_b_q;
    assign reg_out = reg_out_q;
    assign pc      = pc_q;
    assign c_flag  = c_flag_q;

endmodule

// File: tb/tb_td4_register_stage.sv
// Directed bench for td4_register_stage; the step scenario runs only when TD4_STEP_EN is defined.
module tb_td4_register_stage;

    logic       clk;
    logic       n_reset;
    logic [3:0] sum;
    logic       carry_out;
    logic [3:0] load_n;
`ifdef TD4_STEP_EN
    logic       step;
`endif
    logic [3:0] reg_a, reg_b, reg_out, pc;
    logic       c_flag;

    int passed = 0;
    int total  = 0;

    td4_register_stage #(.WIDTH(4), .PC_WIDTH(4)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .sum       (sum),
        .carry_out (carry_out),
        .load_n    (load_n),
`ifdef TD4_STEP_EN
        .step      (step),
`endif
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .reg_out   (reg_out),
        .pc        (pc),
        .c_flag    (c_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; inputs left idle.
    task automatic reset_dut();
        sum = 4'h0; carry_out = 1'b0; load_n = 4'b1111;
        n_reset = 1'b0;
        #2;
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [16:0] st;
        n_reset = 1'b0; sum = 4'h0; carry_out = 1'b0; load_n = 4'b1111;
        repeat (2) tick();
        st = {reg_a, reg_b, reg_out, pc, c_flag};
        total++;
        if (st !== 17'h0) $display("FAIL reset_initial actual=%h required=%h", st, 17'h0);
        else passed++;
        n_reset = 1'b1;
        sum = 4'hA; carry_out = 1'b1; load_n = 4'b0000;
        tick();
        st = {reg_a, reg_b, reg_out, pc, c_flag};
        total++;
        if (st !== {4'hA, 4'hA, 4'hA, 4'hA, 1'b1}) $display("FAIL reset_preload actual=%h required=%h", st, {4'hA, 4'hA, 4'hA, 4'hA, 1'b1});
        else passed++;
        #3;
        n_reset = 1'b0;
        #1;
        st = {reg_a, reg_b, reg_out, pc, c_flag};
        total++;
        if (st !== 17'h0) $display("FAIL reset_async actual=%h required=%h", st, 17'h0);
        else passed++;
        tick();
        st = {reg_a, reg_b, reg_out, pc, c_flag};
        total++;
        if (st !== 17'h0) $display("FAIL reset_hold actual=%h required=%h", st, 17'h0);
        else passed++;
        sum = 4'h0; carry_out = 1'b0; load_n = 4'b1111;
        n_reset = 1'b1;
        tick();
        total++;
        if (pc !== 4'h1) $display("FAIL reset_first_update pc actual=%h required=%h", pc, 4'h1);
        else passed++;
    endtask

    task automatic test_run();
        logic [3:0] exp_pc;
        reset_dut();
        total++;
        if (pc !== 4'h0) $display("FAIL run_start pc actual=%h required=%h", pc, 4'h0);
        else passed++;
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_pc = 4'((i + 1) % 16);
            total++;
            if ({pc, reg_a, reg_b, reg_out} !== {exp_pc, 12'h000})
                $display("FAIL run_step%0d actual pc=%h a=%h b=%h out=%h required pc=%h regs=0", i, pc, reg_a, reg_b, reg_out, exp_pc);
            else passed++;
        end
    endtask

    task automatic test_loads();
        reset_dut();
        sum = 4'h9; load_n = 4'b1110; tick();
        total++;
        if ({reg_a, reg_b, reg_out} !== 12'h900) $display("FAIL load_a actual=%h required=%h", {reg_a, reg_b, reg_out}, 12'h900);
        else passed++;
        sum = 4'h3; load_n = 4'b1101; tick();
        total++;
        if ({reg_a, reg_b, reg_out} !== 12'h930) $display("FAIL load_b actual=%h required=%h", {reg_a, reg_b, reg_out}, 12'h930);
        else passed++;
        sum = 4'hF; load_n = 4'b1011; tick();
        total++;
        if ({reg_a, reg_b, reg_out, pc} !== 16'h93F3) $display("FAIL load_out actual=%h required=%h", {reg_a, reg_b, reg_out, pc}, 16'h93F3);
        else passed++;
    endtask

    task automatic test_jump_flag();
        reset_dut();
        sum = 4'h5; load_n = 4'b0111; tick();
        total++;
        if (pc !== 4'h5) $display("FAIL jump_setup pc actual=%h required=%h", pc, 4'h5);
        else passed++;
        sum = 4'hC; load_n = 4'b0111; carry_out = 1'b1; tick();
        total++;
        if ({pc, c_flag} !== {4'hC, 1'b1}) $display("FAIL jump_taken actual pc=%h c=%b required pc=c c=1", pc, c_flag);
        else passed++;
        sum = 4'h2; load_n = 4'b1111; carry_out = 1'b0; tick();
        total++;
        if ({pc, c_flag, reg_a} !== {4'hD, 1'b0, 4'h0}) $display("FAIL jump_follow actual pc=%h c=%b a=%h required pc=d c=0 a=0", pc, c_flag, reg_a);
        else passed++;
    endtask

    task automatic test_back_to_back();
        reset_dut();
        sum = 4'h6; load_n = 4'b0000; tick();
        total++;
        if ({reg_a, reg_b, reg_out, pc} !== 16'h6666) $display("FAIL multi_load actual=%h required=%h", {reg_a, reg_b, reg_out, pc}, 16'h6666);
        else passed++;
        sum = 4'h1; load_n = 4'b1111; carry_out = 1'b1; tick();
        total++;
        if ({reg_a, reg_b, reg_out, pc, c_flag} !== {16'h6667, 1'b1}) $display("FAIL noop_cycle actual=%h required=%h", {reg_a, reg_b, reg_out, pc, c_flag}, {16'h6667, 1'b1});
        else passed++;
        sum = 4'hF; load_n = 4'b0111; carry_out = 1'b0; tick();
        sum = 4'h4; load_n = 4'b1111; tick();
        total++;
        if (pc !== 4'h0) $display("FAIL pc_wrap actual=%h required=%h", pc, 4'h0);
        else passed++;
    endtask

`ifdef TD4_STEP_EN
    task automatic test_step();
        reset_dut();
        step = 1'b0; sum = 4'h7; load_n = 4'b1110; carry_out = 1'b1;
        repeat (3) tick();
        total++;
        if ({reg_a, pc, c_flag} !== 9'h0) $display("FAIL step_hold actual=%h required=%h", {reg_a, pc, c_flag}, 9'h0);
        else passed++;
        step = 1'b1; tick();
        total++;
        if ({reg_a, pc, c_flag} !== {4'h7, 4'h1, 1'b1}) $display("FAIL step_advance actual=%h required=%h", {reg_a, pc, c_flag}, {4'h7, 4'h1, 1'b1});
        else passed++;
    endtask
`endif

    initial begin
`ifdef TD4_STEP_EN
        step = 1'b1;
`endif
        test_reset();
        test_run();
        test_loads();
        test_jump_flag();
        test_back_to_back();
`ifdef TD4_STEP_EN
        test_step();
        step = 1'b1;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
